cnn_state_update: RTL and testbench



---
 rtl/cnn_pkg.sv | 28 ++
 rtl/cnn_pwl_sat.sv | 31 +++
 rtl/cnn_state_update.sv | 150 +++++++++++++++
 tb/tb_cnn_state_update.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnn_pkg
// Description : Shared defaults, state encoding and fixed-point helpers for
//               the cellular-network cell datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

   localparam int WIDTH_DEF = 9;
   localparam int FRAC_DEF  = 4;
   localparam int ONE_DEF   = 1 << FRAC_DEF;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WAIT  = 3'd1,
      ST_INTEG = 3'd2,
      ST_OUT   = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Fixed-point representation of 1.0 for a given number of fraction bits.
   function automatic int one_of(input int frac);
      return 1 << frac;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cnn_pwl_sat.sv
`default_nettype none
// ============================================================================
// Module      : cnn_pwl_sat
// Description : Piecewise-linear cell output: clamps a signed fixed-point
//               value to [-ONE, +ONE]. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module cnn_pwl_sat
   import cnn_pkg::*;
#(
   parameter int W    = 2 * WIDTH_DEF,
   parameter int FRAC = FRAC_DEF
) (
   input  logic signed [W-1:0] din,
   output logic signed [W-1:0] dout
);

   localparam logic signed [W-1:0] POS = W'(one_of(FRAC));
   localparam logic signed [W-1:0] NEG = -POS;

   // Pass through inside the linear region, saturate outside it.
   always_comb begin
      dout = din;
      if (din > POS)
         dout = POS;
      else if (din < NEG)
         dout = NEG;
   end

endmodule
`default_nettype wire

// File: rtl/cnn_state_update.sv
`default_nettype none
// ============================================================================
// Module      : cnn_state_update
// Description : Per-cell Euler state integrator with PWL output, iteration
//               counting and convergence detection.
// Revision    : 1.0 - initial release
// ============================================================================
module cnn_state_update
   import cnn_pkg::*;
#(
   parameter int WIDTH    = WIDTH_DEF,
   parameter int FRAC     = FRAC_DEF,
   parameter int DT_SHIFT = 3,
   parameter int ITER_W   = 8,
   parameter int CONV_TH  = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      init_load,
   input  logic signed [2*WIDTH-1:0] x_init,
   input  logic [ITER_W-1:0]         max_iter,
   input  logic                      fin_flag,
   input  logic signed [2*WIDTH-1:0] sum_in,
   output logic signed [2*WIDTH-1:0] y_out,
   output logic                      y_valid,
   output logic signed [2*WIDTH-1:0] x_out,
   output logic [ITER_W-1:0]         iter_cnt,
   output logic                      busy,
   output logic                      done,
   output logic                      converged,
   output logic                      overrun
);

   localparam int             SW = 2 * WIDTH;
   localparam logic [SW:0]    TH = (SW+1)'(CONV_TH);

   state_t                  state, state_next;
   logic                    fin_q;
   logic                    rise;
   logic signed [SW-1:0]    x, s, y_sat;
   logic signed [SW:0]      d, step, delta;
   logic [SW:0]             delta_mag;
   logic [ITER_W-1:0]       iter_inc;
   logic                    conv_hit;
   logic                    capture, integ, emit, ovr_set;

   assign rise      = fin_flag & ~fin_q;
   // One extra bit so s - x never wraps; the step then always lands between x and s.
   assign d         = {s[SW-1], s} - {x[SW-1], x};
   assign step      = d >>> DT_SHIFT;
   assign delta_mag = delta[SW] ? -delta : delta;
   assign conv_hit  = (delta_mag <= TH);
   assign iter_inc  = iter_cnt + ITER_W'(1);

   assign x_out = x;
   assign busy  = (state == ST_WAIT) || (state == ST_INTEG) || (state == ST_OUT);
   assign done  = (state == ST_DONE);

   cnn_pwl_sat #(.W(SW), .FRAC(FRAC)) u_sat (
      .din  (x),
      .dout (y_sat)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   // Next-state and datapath strobes; init_load overrides everything, including a rise.
   always_comb begin
      state_next = state;
      capture    = 1'b0;
      integ      = 1'b0;
      emit       = 1'b0;
      ovr_set    = 1'b0;
      if (init_load) begin
         state_next = ST_WAIT;
      end else begin
         case (state)
            ST_WAIT: begin
               if (rise) begin
                  capture    = 1'b1;
                  state_next = ST_INTEG;
               end
            end
            ST_INTEG: begin
               integ      = 1'b1;
               ovr_set    = rise;
               state_next = ST_OUT;
            end
            ST_OUT: begin
               emit    = 1'b1;
               ovr_set = rise;
               if (conv_hit)
                  state_next = ST_DONE;
               else if ((max_iter != '0) && (iter_inc == max_iter))
                  state_next = ST_DONE;
               else
                  state_next = ST_WAIT;
            end
            default: state_next = state;
         endcase
      end
   end

   // Datapath registers: edge detect, sum capture, Euler step, output and flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fin_q     <= 1'b0;
         x         <= '0;
         s         <= '0;
         delta     <= '0;
         y_out     <= '0;
         y_valid   <= 1'b0;
         iter_cnt  <= '0;
         converged <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         fin_q   <= fin_flag;
         y_valid <= 1'b0;
         if (init_load) begin
            x         <= x_init;
            iter_cnt  <= '0;
            converged <= 1'b0;
            overrun   <= 1'b0;
         end else begin
            if (ovr_set)
               overrun <= 1'b1;
            if (capture)
               s <= sum_in;
            if (integ) begin
               x     <= x + step[SW-1:0];
               delta <= step;
            end
            if (emit) begin
               y_out    <= y_sat;
               y_valid  <= 1'b1;
               iter_cnt <= iter_inc;
               if (conv_hit)
                  converged <= 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cnn_state_update.sv
`default_nettype none
// ============================================================================
// Module      : tb_cnn_state_update
// Description : Scoreboard bench for cnn_state_update with a behavioural
//               reference model of the Euler integrator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cnn_state_update;

   localparam int W2 = 18;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 init_load;
   logic signed [W2-1:0] x_init;
   logic [7:0]           max_iter;
   logic                 fin_flag;
   logic signed [W2-1:0] sum_in;
   logic signed [W2-1:0] y_out;
   logic                 y_valid;
   logic signed [W2-1:0] x_out;
   logic [7:0]           iter_cnt;
   logic                 busy, done, converged, overrun;

   cnn_state_update dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .init_load (init_load),
      .x_init    (x_init),
      .max_iter  (max_iter),
      .fin_flag  (fin_flag),
      .sum_in    (sum_in),
      .y_out     (y_out),
      .y_valid   (y_valid),
      .x_out     (x_out),
      .iter_cnt  (iter_cnt),
      .busy      (busy),
      .done      (done),
      .converged (converged),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint y;
      longint x;
      int     iter;
      int     dn;
      int     cv;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   vcount = 0;

   // Reference model state.
   bit     m_run = 0;
   longint m_x   = 0;
   int     m_iter = 0;
   int     m_max  = 0;

   function automatic void chk(input string nm, input logic signed [63:0] act,
                               input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", nm, act, exp);
      end
   endfunction

   function automatic longint floor_div8(input longint v);
      if (v >= 0) return v / 8;
      return -((-v + 7) / 8);
   endfunction

   // One accepted template sum: x moves 1/8 of the way toward s, rounding down.
   function automatic void model_rise(input longint s);
      exp_t   e;
      longint st;
      if (!m_run) return;
      st     = floor_div8(s - m_x);
      m_x    = m_x + st;
      m_iter = (m_iter + 1) % 256;
      e.x    = m_x;
      e.y    = (m_x > 16) ? 16 : ((m_x < -16) ? -16 : m_x);
      e.iter = m_iter;
      e.cv   = (st == 0) ? 1 : 0;
      e.dn   = (e.cv == 1 || (m_max != 0 && m_iter == m_max)) ? 1 : 0;
      if (e.dn == 1) m_run = 0;
      q.push_back(e);
   endfunction

   // Monitor: every y_valid must match the oldest expected result.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1 && y_valid === 1'b1) begin
         vcount++;
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_y_valid: got y_out=%0d, required no output", y_out);
         end else begin
            e = q.pop_front();
            chk("y_out",     64'(y_out),     e.y);
            chk("x_out",     64'(x_out),     e.x);
            chk("iter_cnt",  64'(iter_cnt),  64'(e.iter));
            chk("done",      64'(done),      64'(e.dn));
            chk("converged", 64'(converged), 64'(e.cv));
         end
      end
   end

   task automatic do_init(input longint x0, input int mx);
      @(posedge clk) #1;
      init_load = 1'b1;
      x_init    = W2'(x0);
      max_iter  = 8'(mx);
      m_x = x0; m_iter = 0; m_max = mx; m_run = 1;
      @(posedge clk) #1;
      init_load = 1'b0;
   endtask

   task automatic pulse_sum(input longint v, input int gap);
      @(posedge clk) #1;
      fin_flag = 1'b1;
      sum_in   = W2'(v);
      model_rise(v);
      @(posedge clk) #1;
      fin_flag = 1'b0;
      repeat (gap) @(posedge clk);
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      chk("queue_drained", 64'(q.size()), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, required finish");
      $fatal(1, "timeout");
   end

   initial begin
      int v0;
      rst_n = 1'b0; init_load = 1'b0; x_init = '0; max_iter = '0;
      fin_flag = 1'b0; sum_in = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_y_out", 64'(y_out), 0);
      chk("rst_y_valid", 64'(y_valid), 0);
      chk("rst_x_out", 64'(x_out), 0);
      chk("rst_iter", 64'(iter_cnt), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_done", 64'(done), 0);
      chk("rst_conv", 64'(converged), 0);
      chk("rst_overrun", 64'(overrun), 0);
      rst_n = 1'b1;

      // Basic step, then clamp.
      do_init(0, 0);
      pulse_sum(80, 3);
      @(negedge clk);
      chk("basic_busy", 64'(busy), 1);
      pulse_sum(80, 3);
      drain();
      // Negative floor rounding.
      do_init(0, 0);
      pulse_sum(-9, 3);
      drain();

      // Convergence; a later rise must produce nothing.
      do_init(10, 0);
      pulse_sum(10, 3);
      drain();
      v0 = vcount;
      pulse_sum(200, 5);
      chk("after_done_no_valid", 64'(vcount), 64'(v0));
      chk("after_done_done", 64'(done), 1);

      // Iteration limit.
      do_init(0, 3);
      pulse_sum(800, 3);
      pulse_sum(-800, 3);
      pulse_sum(800, 3);
      drain();
      v0 = vcount;
      pulse_sum(800, 5);
      chk("limit_no_extra", 64'(vcount), 64'(v0));

      // Rise while the iteration is still in flight.
      do_init(5, 0);
      v0 = vcount;
      @(posedge clk) #1; fin_flag = 1'b1; sum_in = 100; model_rise(100);
      @(posedge clk) #1; fin_flag = 1'b0;
      @(posedge clk) #1; fin_flag = 1'b1; sum_in = 999;
      @(posedge clk) #1; fin_flag = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("overrun_set", 64'(overrun), 1);
      chk("overrun_one_valid", 64'(vcount), 64'(v0 + 1));

      // init_load with a simultaneous rise: restart wins, rise discarded.
      v0 = vcount;
      @(posedge clk) #1;
      init_load = 1'b1; x_init = -37; fin_flag = 1'b1; sum_in = 500;
      m_x = -37; m_iter = 0; m_max = 0; m_run = 1;
      @(posedge clk) #1; init_load = 1'b0; fin_flag = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("collide_x", 64'(x_out), -37);
      chk("collide_busy", 64'(busy), 1);
      chk("collide_no_valid", 64'(vcount), 64'(v0));
      chk("collide_ovr_clr", 64'(overrun), 0);
      pulse_sum(3, 3);
      drain();

      // Reset while integrating.
      do_init(0, 0);
      @(posedge clk) #1; fin_flag = 1'b1; sum_in = 50;
      @(posedge clk) #1; rst_n = 1'b0; fin_flag = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_y_out", 64'(y_out), 0);
      chk("midrst_x_out", 64'(x_out), 0);
      chk("midrst_busy", 64'(busy), 0);
      chk("midrst_iter", 64'(iter_cnt), 0);
      chk("midrst_y_valid", 64'(y_valid), 0);
      #1 rst_n = 1'b1;
      m_run = 0;
      v0 = vcount;
      pulse_sum(30, 5);
      @(negedge clk);
      chk("midrst_ignored", 64'(vcount), 64'(v0));
      chk("midrst_idle", 64'(busy), 0);
      do_init(-20, 0);
      pulse_sum(-100, 3);
      drain();

      // Randomized runs against the model.
      for (int r = 0; r < 12; r++) begin
         do_init(longint'($urandom_range(4000)) - 2000, int'($urandom_range(5)));
         for (int k = 0; k < 8; k++)
            pulse_sum(longint'($urandom_range(6000)) - 3000, int'($urandom_range(6, 2)));
         drain();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
